// File: rtl/nonce_pkg.sv
// Shared types for the nonce dispatcher: FSM state encoding and nonce type.
package nonce_pkg;

    localparam int DEFAULT_NONCE_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        DISPATCH,
        DRAIN,
        DONE
    } dispatch_state_t;

    typedef logic [DEFAULT_NONCE_WIDTH-1:0] nonce_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int NUM_CORES = 4,
    localparam int PTR_W = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [PTR_W-1:0]     ptr_i,
    output logic [NUM_CORES-1:0] grant_o,
    output logic                 valid_o
);

    // NOTE: every comb output gets a default first; a path that skips an assignment would infer a latch.
    always_comb begin
        int idx;
        grant_o = '0;
        valid_o = 1'b0;
        for (int off = 0; off < NUM_CORES; off++) begin
            idx = (int'(ptr_i) + off) % NUM_CORES;
            if (!valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nonce_dispatcher.sv
// Job controller: restarts the nonce generator, hands nonces round-robin to idle cores,
// stops on the first golden nonce or exhaustion, and drains in-flight cores before reporting.
module nonce_dispatcher
    import nonce_pkg::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int NONCE_WIDTH = DEFAULT_NONCE_WIDTH
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [NUM_CORES-1:0]             core_req,
    output logic [NUM_CORES-1:0]             core_grant,
    output logic [NONCE_WIDTH-1:0]           dispatch_nonce,
    input  logic [NUM_CORES-1:0]             core_done,
    input  logic [NUM_CORES-1:0]             core_found,
    input  logic [NUM_CORES*NONCE_WIDTH-1:0] core_result,
    output logic                             gen_enable,
    output logic                             gen_restart,
    input  logic [NONCE_WIDTH-1:0]           gen_nonce,
    input  logic                             gen_overflow,
    output logic                             busy,
    output logic                             found,
    output logic [NONCE_WIDTH-1:0]           found_nonce,
    output logic                             exhausted
);

    localparam int PTR_W = $clog2(NUM_CORES);

    dispatch_state_t        state_q, state_d;
    logic [NUM_CORES-1:0]   in_flight_q, in_flight_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   captured_q, captured_d;
    logic [NONCE_WIDTH-1:0] found_nonce_q, found_nonce_d;

    logic [NUM_CORES-1:0]   done_vld, find_vec, eligible, arb_grant, grant_vec;
    logic                   arb_valid, any_find, grant_ok, start_ok;
    logic [NONCE_WIDTH-1:0] find_nonce;
    logic [PTR_W-1:0]       gnt_idx;

    // Dones from cores that hold no nonce are ignored.
    assign done_vld = core_done & in_flight_q;
    assign find_vec = done_vld & core_found;
    assign any_find = |find_vec;
    assign eligible = core_req & ~in_flight_q;
    assign start_ok = start && (state_q == IDLE || state_q == DONE);

    rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
        .req_i   (eligible),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .valid_o (arb_valid)
    );

    assign grant_ok  = (state_q == DISPATCH) && !abort && !any_find && !gen_overflow && arb_valid;
    assign grant_vec = grant_ok ? arb_grant : '0;

    always_comb begin
        find_nonce = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (find_vec[i]) find_nonce = core_result[i*NONCE_WIDTH +: NONCE_WIDTH];
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (arb_grant[i]) gnt_idx = PTR_W'(i);
        end
    end

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (start) state_d = CLEAR;
                CLEAR:    state_d = DISPATCH;
                DISPATCH: if (any_find || gen_overflow) state_d = DRAIN;
                DRAIN:    if (in_flight_d == '0) state_d = DONE;
                DONE:     if (start) state_d = CLEAR;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        core_grant     = grant_vec;
        dispatch_nonce = grant_ok ? gen_nonce : '0;
        gen_enable     = grant_ok;
        gen_restart    = (state_q == CLEAR) && !abort;
        busy           = (state_q == CLEAR) || (state_q == DISPATCH) || (state_q == DRAIN);
        found          = (state_q == DONE) && captured_q;
        exhausted      = (state_q == DONE) && !captured_q;
        found_nonce    = found_nonce_q;
    end

    always_comb begin
        in_flight_d   = in_flight_q;
        rr_ptr_d      = rr_ptr_q;
        captured_d    = captured_q;
        found_nonce_d = found_nonce_q;
        if (abort || start_ok || state_q == CLEAR) begin
            in_flight_d   = '0;
            captured_d    = 1'b0;
            found_nonce_d = '0;
        end else if (state_q != IDLE) begin
            // A grant and a done for the same core in one cycle leave the bit set.
            in_flight_d = (in_flight_q & ~done_vld) | grant_vec;
            if (grant_ok) begin
                rr_ptr_d = (gnt_idx == PTR_W'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if ((state_q == DISPATCH || state_q == DRAIN) && any_find && !captured_q) begin
                captured_d    = 1'b1;
                found_nonce_d = find_nonce;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            in_flight_q   <= '0;
            rr_ptr_q      <= '0;
            captured_q    <= 1'b0;
            found_nonce_q <= '0;
        end else begin
            in_flight_q   <= in_flight_d;
            rr_ptr_q      <= rr_ptr_d;
            captured_q    <= captured_d;
            found_nonce_q <= found_nonce_d;
        end
    end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Scoreboard bench for nonce_dispatcher: behavioural cores and generator drive the DUT,
// expected grants are queued per test and a monitor compares every grant it sees.
module tb_nonce_dispatcher;
    import nonce_pkg::*;

    localparam int NC = 4;
    localparam int NW = 32;

    logic              clk = 1'b0;
    logic              n_rst, start, abort;
    logic [NC-1:0]     core_req, core_grant, core_done, core_found;
    logic [NC*NW-1:0]  core_result;
    logic [NW-1:0]     dispatch_nonce, gen_nonce, found_nonce;
    logic              gen_enable, gen_restart, gen_overflow, busy, found, exhausted;

    nonce_dispatcher #(.NUM_CORES(NC), .NONCE_WIDTH(NW)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .start          (start),
        .abort          (abort),
        .core_req       (core_req),
        .core_grant     (core_grant),
        .dispatch_nonce (dispatch_nonce),
        .core_done      (core_done),
        .core_found     (core_found),
        .core_result    (core_result),
        .gen_enable     (gen_enable),
        .gen_restart    (gen_restart),
        .gen_nonce      (gen_nonce),
        .gen_overflow   (gen_overflow),
        .busy           (busy),
        .found          (found),
        .found_nonce    (found_nonce),
        .exhausted      (exhausted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     core;
        nonce_t nonce;
    } exp_grant_t;

    exp_grant_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int restarts = 0;
    int last_done_cyc = 0;
    int done_cyc = -1;
    bit prev_end = 1'b0;

    // Behavioural core / generator model state.
    bit     req_en[NC];
    int     lat[NC];
    int     budget[NC];
    bit     busy_m[NC];
    int     cnt[NC];
    nonce_t assigned[NC];
    nonce_t targets[$];
    nonce_t gen_base;
    bit     model_clear;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_grant(input int core, input nonce_t nonce);
        sb_q.push_back('{core: core, nonce: nonce});
    endtask

    // Monitor: pops the scoreboard on every grant, counts restart pulses, timestamps DONE.
    initial begin : monitor
        exp_grant_t e;
        forever begin
            @(negedge clk);
            if (gen_restart) restarts++;
            if (core_grant != '0 || gen_enable) begin
                check("gen_enable_vs_grant", 64'(gen_enable), 64'(core_grant != '0));
                check("grant_onehot", 64'($onehot(core_grant)), 64'd1);
                if (sb_q.size() == 0) begin
                    check("unexpected_grant", 64'(core_grant), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("grant_core", 64'(core_grant), 64'(1 << e.core));
                    check("grant_nonce", 64'(dispatch_nonce), 64'(e.nonce));
                end
            end
            if ((found || exhausted) && !prev_end) done_cyc = cyc;
            prev_end = found || exhausted;
        end
    end

    // Driver: cores with per-core latency/budget and the nonce generator.
    initial begin : driver
        logic [NC-1:0]    smp_grant, dv, fv;
        logic [NC*NW-1:0] rv;
        logic [NW-1:0]    smp_nonce;
        logic             smp_en, smp_rst;
        core_req     = '0;
        core_done    = '0;
        core_found   = '0;
        core_result  = '0;
        gen_nonce    = '0;
        gen_overflow = 1'b0;
        forever begin
            @(negedge clk);
            smp_grant = core_grant;
            smp_nonce = dispatch_nonce;
            smp_en    = gen_enable;
            smp_rst   = gen_restart;
            for (int i = 0; i < NC; i++) begin
                if (smp_grant[i]) begin
                    busy_m[i]   = 1'b1;
                    cnt[i]      = lat[i];
                    assigned[i] = smp_nonce;
                    budget[i]   = budget[i] - 1;
                end
            end
            @(posedge clk);
            #1;
            if (!n_rst) begin
                gen_nonce    = '0;
                gen_overflow = 1'b0;
            end else if (smp_rst) begin
                gen_nonce    = gen_base;
                gen_overflow = 1'b0;
            end else if (smp_en) begin
                if (gen_nonce == '1) gen_overflow = 1'b1;
                gen_nonce = gen_nonce + 1'b1;
            end
            if (model_clear) begin
                for (int i = 0; i < NC; i++) busy_m[i] = 1'b0;
                model_clear = 1'b0;
            end
            dv = '0;
            fv = '0;
            rv = '0;
            for (int i = 0; i < NC; i++) begin
                if (busy_m[i]) begin
                    cnt[i] = cnt[i] - 1;
                    if (cnt[i] <= 0) begin
                        dv[i] = 1'b1;
                        rv[i*NW +: NW] = assigned[i];
                        foreach (targets[t]) if (targets[t] == assigned[i]) fv[i] = 1'b1;
                        busy_m[i] = 1'b0;
                        last_done_cyc = cyc;
                    end
                end
            end
            for (int i = 0; i < NC; i++) begin
                core_req[i] = req_en[i] && !busy_m[i] && (budget[i] > 0) && !dv[i];
            end
            core_done   = dv;
            core_found  = fv;
            core_result = rv;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        check("async_reset_busy", 64'(busy), 64'd0);
        check("async_reset_grant", 64'(core_grant), 64'd0);
        model_clear = 1'b1;
        sb_q.delete();
        targets.delete();
        repeat (2) @(posedge clk);
        #3 n_rst = 1'b1;
    endtask

    task automatic cfg(input logic [NC-1:0] req_mask, input int lat_all, input int budget_all);
        @(posedge clk);
        #3;
        for (int i = 0; i < NC; i++) begin
            req_en[i] = req_mask[i];
            lat[i]    = lat_all;
            budget[i] = budget_all;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_sb(input string name, input int max_cyc);
        int n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_grants_seen"}, 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int n = 0;
        while (!(found || exhausted) && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_done_reached"}, 64'(found || exhausted), 64'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no summary by 200us, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int r0;
        n_rst       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        gen_base    = '0;
        model_clear = 1'b0;
        repeat (3) @(posedge clk);
        #3 n_rst = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_found", 64'(found), 64'd0);
        check("rst_exhausted", 64'(exhausted), 64'd0);
        check("rst_found_nonce", 64'(found_nonce), 64'd0);
        check("rst_grant", 64'(core_grant), 64'd0);
        check("rst_gen_enable", 64'(gen_enable), 64'd0);
        check("rst_gen_restart", 64'(gen_restart), 64'd0);

        // Basic job: all cores, done 5 cycles after grant; core 0 gets a second nonce
        cfg(4'b1111, 5, 1);
        budget[0] = 2;
        gen_base  = '0;
        r0 = restarts;
        expect_grant(0, 32'd0);
        expect_grant(1, 32'd1);
        expect_grant(2, 32'd2);
        expect_grant(3, 32'd3);
        expect_grant(0, 32'd4);
        pulse_start();
        wait_sb("basic", 40);
        check("basic_restart_pulses", 64'(restarts - r0), 64'd1);
        check("basic_busy", 64'(busy), 64'd1);
        do_reset();

        // Round-robin between cores 1 and 3
        cfg(4'b1010, 1, 2);
        expect_grant(1, 32'd0);
        expect_grant(3, 32'd1);
        expect_grant(1, 32'd2);
        expect_grant(3, 32'd3);
        pulse_start();
        wait_sb("rr", 40);
        do_reset();

        // Find with drain: core 2 finds 0x123 while cores 0 and 1 are in flight
        cfg(4'b1111, 6, 1);
        lat[2]   = 1;
        gen_base = 32'h121;
        targets.push_back(32'h123);
        r0 = restarts;
        expect_grant(0, 32'h121);
        expect_grant(1, 32'h122);
        expect_grant(2, 32'h123);
        pulse_start();
        wait_sb("find", 40);
        @(posedge clk);
        pulse_start();
        wait_done("find", 40);
        check("find_found", 64'(found), 64'd1);
        check("find_nonce", 64'(found_nonce), 64'h123);
        check("find_exhausted", 64'(exhausted), 64'd0);
        check("find_done_after_drain", 64'(done_cyc), 64'(last_done_cyc + 1));
        check("find_start_ignored", 64'(restarts - r0), 64'd1);
        do_reset();

        // Simultaneous finds from cores 1 and 3
        cfg(4'b1010, 1, 1);
        lat[1]   = 2;
        gen_base = 32'hA;
        targets.push_back(32'hA);
        targets.push_back(32'hB);
        expect_grant(1, 32'hA);
        expect_grant(3, 32'hB);
        pulse_start();
        wait_sb("simfind", 40);
        wait_done("simfind", 40);
        check("simfind_found", 64'(found), 64'd1);
        check("simfind_nonce", 64'(found_nonce), 64'hA);
        check("simfind_exhausted", 64'(exhausted), 64'd0);

        // Exhaustion, restarted straight from DONE
        targets.delete();
        cfg(4'b1111, 3, 1);
        gen_base = 32'hFFFF_FFFD;
        r0 = restarts;
        expect_grant(0, 32'hFFFF_FFFD);
        expect_grant(1, 32'hFFFF_FFFE);
        expect_grant(2, 32'hFFFF_FFFF);
        pulse_start();
        wait_sb("exhaust", 40);
        wait_done("exhaust", 40);
        check("exhaust_exhausted", 64'(exhausted), 64'd1);
        check("exhaust_found", 64'(found), 64'd0);
        check("exhaust_found_nonce", 64'(found_nonce), 64'd0);
        check("exhaust_done_after_drain", 64'(done_cyc), 64'(last_done_cyc + 1));
        check("exhaust_restart_pulses", 64'(restarts - r0), 64'd1);
        repeat (4) @(negedge clk);
        check("exhaust_held", 64'(exhausted), 64'd1);

        // Abort with three cores in flight, then restart
        do_reset();
        cfg(4'b0111, 20, 1);
        gen_base = '0;
        r0 = restarts;
        expect_grant(0, 32'd0);
        expect_grant(1, 32'd1);
        expect_grant(2, 32'd2);
        pulse_start();
        wait_sb("abort", 40);
        check("abort_busy_before", 64'(busy), 64'd1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy_after", 64'(busy), 64'd0);
        check("abort_found", 64'(found), 64'd0);
        check("abort_exhausted", 64'(exhausted), 64'd0);
        check("abort_no_restart", 64'(restarts - r0), 64'd1);
        @(posedge clk);
        #3 model_clear = 1'b1;
        cfg(4'b1111, 2, 1);
        expect_grant(3, 32'd0);
        expect_grant(0, 32'd1);
        expect_grant(1, 32'd2);
        expect_grant(2, 32'd3);
        pulse_start();
        wait_sb("restart", 40);
        check("restart_pulses", 64'(restarts - r0), 64'd2);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nonce_dispatcher.md
Name: nonce_dispatcher

Overview:
Job-level controller that sequences the nonce generator and shares its nonce stream among NUM_CORES hash cores.
- Restarts the generator at job start.
- Hands out one nonce per grant to idle cores, round-robin.
- Advances the generator once per grant.
- Stops on the first golden nonce or on nonce-space exhaustion, then drains in-flight cores before reporting.

Parameters:
NUM_CORES, 4, number of hash cores arbitrated (2..16)
NONCE_WIDTH, 32, nonce width; must match the generator

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous, active-low reset
start  in  1  1-cycle pulse: begin new job; honoured only in IDLE or DONE
abort  in  1  level/pulse: cancel job; returns to IDLE next edge
core_req  in  NUM_CORES  per-core "idle, want a nonce"
core_grant  out  NUM_CORES  one-hot, 1-cycle pulse; at most one bit set per cycle
dispatch_nonce  out  NONCE_WIDTH  nonce for the granted core; valid only while core_grant != 0
core_done  in  NUM_CORES  per-core 1-cycle pulse: assigned nonce fully checked
core_found  in  NUM_CORES  qualified by core_done: the core's nonce met target
core_result  in  NUM_CORES*NONCE_WIDTH  packed; slice i = nonce core i checked, valid with core_done[i]
gen_enable  out  1  advance generator (to nonceGenerator enable)
gen_restart  out  1  clear generator to start value (to nonceGenerator restart)
gen_nonce  in  NONCE_WIDTH  current generator value
gen_overflow  in  1  generator has stepped past the last nonce; sticky until restart
busy  out  1  job in progress (CLEAR, DISPATCH, DRAIN)
found  out  1  level in DONE: golden nonce located
found_nonce  out  NONCE_WIDTH  golden nonce; held until next start/abort
exhausted  out  1  level in DONE: space exhausted with no find

Behaviour:
- Reset:
  - state=IDLE
  - all outputs 0
  - in_flight mask 0
  - rr pointer 0
- FSM states: IDLE, CLEAR, DISPATCH, DRAIN, DONE.
- IDLE -> CLEAR on start.
- CLEAR:
  - gen_restart=1 for exactly one cycle, no grants.
  - Clears in_flight, found, found_nonce, exhausted.
  - Then goes to DISPATCH.
- DISPATCH:
  - Eligible cores = core_req & ~in_flight.
  - If any core is eligible and gen_overflow=0:
    - Grant the first eligible index at or after rr pointer, wrapping.
    - dispatch_nonce=gen_nonce combinationally in the same cycle.
    - gen_enable=1 in the same cycle.
    - Set in_flight[i]; rr pointer <- i+1 mod NUM_CORES.
  - Grant-to-next-nonce latency is 1 cycle: a grant every cycle is legal, and every nonce is dispatched exactly once.
- core_done[i] (any non-IDLE state) clears in_flight[i]. If granted and done for the same core in one cycle, the grant wins (bit stays set).
- DISPATCH -> DRAIN when either:
  - any core_done&core_found: capture found_nonce from the lowest-index finding core; further finds are ignored;
  - gen_overflow=1: no further grants.
  - If both happen in the same cycle, the find takes precedence.
- DRAIN:
  - No grants; gen_enable=0.
  - Wait until in_flight==0 (the same-cycle done counts), then go to DONE.
  - A find reported during DRAIN is captured only if none was captured yet.
- DONE:
  - found=1 if a nonce was captured, else exhausted=1.
  - Hold until start (-> CLEAR) or abort (-> IDLE).
- busy=1 in CLEAR, DISPATCH, DRAIN.
- abort:
  - Highest priority: any state -> IDLE next edge.
  - Clears in_flight and found/exhausted.
  - No gen_restart issued; the next start restarts the generator.
- start outside IDLE/DONE is ignored.
- core_done for a core not in flight is ignored.
- Mid-operation reset: immediate return to reset values, asynchronously.

Decomposition:
- Package nonce_pkg holds:
  - NONCE_WIDTH default constant;
  - dispatch_state_t enum (IDLE, CLEAR, DISPATCH, DRAIN, DONE);
  - nonce_t typedef logic [NONCE_WIDTH-1:0].
- One sub-module, rr_arbiter (NUM_CORES):
  - inputs req, ptr; output one-hot grant plus valid;
  - purely combinational.
- Pointer and in_flight registers stay in nonce_dispatcher.

Test Plan:
- Basic job, NUM_CORES=4:
  - Reset, start, all core_req=1, cores done 5 cycles after grant, never found.
  - Required: CLEAR issues one gen_restart pulse.
  - Grants go to cores 0,1,2,3 with dispatch_nonce 0,1,2,3.
  - The next grant goes to core 0 with nonce 4 after its done.
- Round-robin fairness:
  - Hold only cores 1 and 3 requesting, each done the cycle after grant.
  - Required: grants alternate 1,3,1,3.
  - Dispatched nonces are strictly consecutive with no gaps or duplicates.
- Find with drain:
  - Core 2 reports found with result 0x0000_0123 while cores 0 and 1 are in flight.
  - Required: grants stop the same cycle; DONE is reached only after both remaining dones.
  - found=1, found_nonce=0x123, exhausted=0.
- Simultaneous finds:
  - Cores 1 and 3 report found in the same cycle with results 0xA and 0xB.
  - Required: found_nonce=0xA.
- Exhaustion:
  - Force gen_overflow=1 after nonce 0xFFFF_FFFF has been granted.
  - Required: no further grants; after the last done, DONE with exhausted=1 and found=0.
- Abort and restart:
  - Abort in DISPATCH with 3 cores in flight.
  - Required: IDLE next cycle, busy=0, in_flight cleared.
  - A following start pulses gen_restart; the first grant carries nonce 0.
